// File: rtl/hue_stage1.sv
// First hue stage: scales the channel difference by 60 and divides it by the channel span
// with a serial restoring divider, then applies the sector offset and wraps into 0..359.
module hue_stage1 #(
  parameter int N_BITS = 14
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [8:0] i_dividend,
  input  logic [8:0] i_divisor,
  input  logic [1:0] i_function,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [8:0] o_hue,
  output logic       o_valid,
  input  logic       i_ready
);

  localparam int CNT_W = $clog2(N_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] num_q, num_d;
  logic [8:0]        rem_q, rem_d;
  logic [8:0]        dvs_q, dvs_d;
  logic [1:0]        func_q, func_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [8:0]        hue_q, hue_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;

  logic              accept_s;
  logic [8:0]        mag_s;
  logic [9:0]        rem_sh_s;
  logic              fits_s;
  logic              bypass_s;
  logic [10:0]       offset_s;
  logic [10:0]       squo_s;
  logic [10:0]       sum_s;
  logic [8:0]        fix_hue_s;

  assign accept_s = i_valid && ready_q;
  assign mag_s    = i_dividend[8] ? (9'd0 - i_dividend) : i_dividend;
  assign rem_sh_s = {rem_q, num_q[N_BITS-1]};
  assign fits_s   = (rem_sh_s >= {1'b0, dvs_q});
  assign bypass_s = (dvs_q == 9'd0) || (func_q == 2'd0);

  // Sector offset and signed-quotient wrap, used only in FIX.
  always_comb begin
    offset_s = 11'd0;
    case (func_q)
      2'd1:    offset_s = 11'd0;
      2'd2:    offset_s = 11'd120;
      2'd3:    offset_s = 11'd240;
      default: offset_s = 11'd0;
    endcase
    if (neg_q) begin
      squo_s = 11'd0 - {2'b00, num_q[8:0]};
    end else begin
      squo_s = {2'b00, num_q[8:0]};
    end
    sum_s = squo_s + offset_s;
    if (sum_s[10]) begin
      fix_hue_s = 9'(sum_s + 11'd360);
    end else begin
      fix_hue_s = sum_s[8:0];
    end
  end

  // Next-state and datapath update for the IDLE/DIV/FIX/DONE sequence.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    func_d  = func_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    hue_d   = hue_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          num_d  = N_BITS'(mag_s) * N_BITS'(6'd60);
          rem_d  = 9'd0;
          dvs_d  = i_divisor;
          func_d = i_function;
          neg_d  = i_dividend[8];
          cnt_d  = '0;
          if ((i_divisor == 9'd0) || (i_function == 2'd0)) begin
            state_d = FIX;
          end else begin
            state_d = DIV;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DIV: begin
        // The numerator register doubles as the quotient shift register.
        if (fits_s) begin
          rem_d = 9'(rem_sh_s - {1'b0, dvs_q});
          num_d = {num_q[N_BITS-2:0], 1'b1};
        end else begin
          rem_d = rem_sh_s[8:0];
          num_d = {num_q[N_BITS-2:0], 1'b0};
        end
        if (cnt_q == CNT_W'(N_BITS - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1'b1);
          state_d = DIV;
        end
      end
      FIX: begin
        if (bypass_s) begin
          hue_d = 9'd0;
        end else begin
          hue_d = fix_hue_s;
        end
        state_d = DONE;
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      rem_q   <= 9'd0;
      dvs_q   <= 9'd0;
      func_q  <= 2'd0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      hue_q   <= 9'd0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      func_q  <= func_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      hue_q   <= hue_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_hue   = hue_q;

endmodule

// File: tb/tb_hue_stage1.sv
// Directed bench for hue_stage1: hand-computed hue values, latency, back-pressure hold and
// mid-division reset.
module tb_hue_stage1;

  logic       clk;
  logic       rst;
  logic [8:0] dividend;
  logic [8:0] divisor;
  logic [1:0] func;
  logic       in_valid;
  logic       out_ready;
  logic [8:0] hue;
  logic       out_valid;
  logic       ds_ready;

  int n_vec;
  int n_err;

  hue_stage1 #(.N_BITS(14)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_dividend (dividend),
    .i_divisor  (divisor),
    .i_function (func),
    .i_valid    (in_valid),
    .o_ready    (out_ready),
    .o_hue      (hue),
    .o_valid    (out_valid),
    .i_ready    (ds_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!out_ready && k < 40) begin
      step();
      k++;
    end
    check_eq({tag, ".rdy"}, int'(out_ready), 1);
  endtask

  // One transaction; hold > 0 keeps downstream stalled that many cycles after o_valid rises.
  task automatic run_op(input string tag, input int f, input int dvd, input int dvs,
                        input int exp_hue, input int exp_lat, input int hold);
    int lat;
    int dv;
    int ds;
    dv = dvd;
    ds = dvs;
    ds_ready = (hold == 0);
    wait_ready(tag);
    func     = f[1:0];
    dividend = dv[8:0];
    divisor  = ds[8:0];
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check_eq({tag, ".lat"}, lat, exp_lat);
    check_eq({tag, ".hue"}, int'(hue), exp_hue);
    for (int h = 0; h < hold; h++) begin
      if (h == 2) begin
        func     = 2'd3;
        dividend = 9'd10;
        divisor  = 9'd20;
        in_valid = 1'b1;
      end
      step();
      in_valid = 1'b0;
      check_eq({tag, ".hold_v"}, int'(out_valid), 1);
      check_eq({tag, ".hold_h"}, int'(hue), exp_hue);
      check_eq({tag, ".hold_r"}, int'(out_ready), 0);
    end
    ds_ready = 1'b1;
    step();
    check_eq({tag, ".v_fall"}, int'(out_valid), 0);
    check_eq({tag, ".r_back"}, int'(out_ready), 1);
  endtask

  initial begin
    int highs;
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    dividend = 9'd0;
    divisor  = 9'd0;
    func     = 2'd0;
    in_valid = 1'b0;
    ds_ready = 1'b1;
    step();
    step();
    check_eq("rst.valid", int'(out_valid), 0);
    check_eq("rst.hue", int'(hue), 0);
    rst = 1'b0;
    step();
    check_eq("rst.ready", int'(out_ready), 1);

    run_op("r_pos",   1,   40,  80,  30, 16, 0);
    run_op("r_neg",   1,  -40,  80, 330, 16, 0);
    run_op("r_zero",  1,    0,  50,   0, 16, 0);
    run_op("g_neg",   2, -100, 200,  90, 16, 0);
    run_op("b_max",   3,  248, 248, 300, 16, 0);
    run_op("b_trunc", 3,   -7,   9, 194, 16, 0);
    run_op("r_m0",    1,   -1, 255,   0, 16, 0);
    run_op("g_255",   2,  255, 255, 180, 16, 0);
    run_op("dz_f1",   1,   40,   0,   0,  2, 0);
    run_op("dz_f3",   3,   -7,   0,   0,  2, 0);
    run_op("f0",      0,   40,  80,   0,  2, 0);
    run_op("f0_dz",   0,    0,   0,   0,  2, 0);
    run_op("stall",   1,   40,  80,  30, 16, 5);

    // Reset pulse while the divider is at iteration 7.
    ds_ready = 1'b1;
    wait_ready("mid");
    func     = 2'd1;
    dividend = 9'd40;
    divisor  = 9'd80;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid.valid", int'(out_valid), 0);
    check_eq("mid.hue", int'(hue), 0);
    step();
    check_eq("mid.ready", int'(out_ready), 1);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid) highs++;
    end
    check_eq("mid.discard", highs, 0);
    run_op("post_rst", 2, 50, 100, 150, 16, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hue_stage1.md
HUE_STAGE1 -- requirements
Module: hue_stage1

Interface
REQ-001 SHALL have parameter N_BITS, default 14: numerator width and the number of division iterations; legal values are 14 or more.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 SHALL have port i_dividend, input, 9 bits: two's-complement difference of the non-max colour channels.
REQ-005 SHALL have port i_divisor, input, 9 bits: unsigned (max - min) channel span, 0..255.
REQ-006 SHALL have port i_function, input, 2 bits: max-channel code; 1=red, 2=green, 3=blue, 0=invalid.
REQ-007 SHALL have port i_valid, input, 1 bit: the input operands are valid.
REQ-008 SHALL have port o_ready, output, 1 bit: the block accepts an input this cycle.
REQ-009 SHALL have port o_hue, output, 9 bits: unsigned hue in degrees, 0..359.
REQ-010 SHALL have port o_valid, output, 1 bit: o_hue is valid.
REQ-011 SHALL have port i_ready, input, 1 bit: downstream accepts o_hue.

Function
REQ-012 SHALL implement the FSM states IDLE, DIV, FIX and DONE.
REQ-013 SHALL drive o_ready=1 only in IDLE; an input is accepted on a rising edge where i_valid=1 and o_ready=1.
REQ-014 SHALL, on acceptance, register |i_dividend|*60 as an N_BITS unsigned numerator, plus the dividend sign, the divisor and the function code.
REQ-015 SHALL go from IDLE to FIX when the accepted divisor is 0 or the function code is 0; otherwise it SHALL go to DIV.
REQ-016 SHALL, in DIV, perform unsigned restoring division one quotient bit per cycle, MSB first, for exactly N_BITS cycles, then go to FIX.
REQ-017 SHALL produce a quotient truncated toward zero (floor of magnitude); the quotient never exceeds 60 for legal inputs.
REQ-018 SHALL, in FIX (one cycle), form the signed quotient by applying the dividend sign, add the offset (function 1: 0, 2: 120, 3: 240), and add 360 if the sum is negative.
REQ-019 SHALL register the FIX result into o_hue, force hue 0 for a zero divisor or function 0, and go to DONE.
REQ-020 SHALL, in DONE, assert o_valid with o_hue stable; on an edge with i_ready=1 it SHALL return to IDLE and deassert o_valid.
REQ-021 SHALL hold o_valid and o_hue unchanged for any number of cycles while i_ready=0.
REQ-022 SHALL ignore i_valid in DIV, FIX and DONE; no input is buffered.
REQ-023 SHALL set latency, counted from the acceptance edge to the edge where o_valid rises, to N_BITS+2 (16 at default) for the division path and 2 for the zero/invalid path.
REQ-024 SHALL sustain throughput of one result per N_BITS+3 cycles minimum, because IDLE lasts at least one cycle.
REQ-025 SHALL produce intermediate values with no overflow: numerator ≤ 15300, and the pre-wrap sum is in the range -60..300.
REQ-026 SHALL never produce o_hue of 360 or more; a wrapped red result of exactly 360 (quotient -0) is produced as 0.

Reset
REQ-027 SHALL, when i_rst=1 at an edge, set the FSM to IDLE, o_valid=0, o_hue=0, the iteration counter=0, and all datapath registers=0.
REQ-028 SHALL allow reset to take effect in any state, including mid-DIV and DONE with i_ready=0; the in-flight result is discarded and never emitted.
REQ-029 SHALL drive o_ready=1 on the first edge after i_rst is released.

Verification
REQ-030 SHALL test function 1, dividend +40, divisor 80 -> o_hue=30, o_valid rising 16 cycles after acceptance.
REQ-031 SHALL test function 1, dividend -40, divisor 80 -> o_hue=330; function 1, dividend 0, divisor 50 -> o_hue=0.
REQ-032 SHALL test function 2, dividend -100, divisor 200 -> o_hue=90; function 3, dividend 248, divisor 248 -> o_hue=300; function 3, dividend -7, divisor 9 -> o_hue=194 (truncation).
REQ-033 SHALL test divisor 0 with any function, and function 0 with any operands -> o_hue=0, latency 2.
REQ-034 SHALL test holding i_ready=0 for 5 cycles in DONE -> o_valid/o_hue hold, o_ready=0, and an i_valid pulse during that time is not accepted; with i_ready=1, o_valid falls on the next edge.
REQ-035 SHALL test i_rst pulsed for one cycle at DIV iteration 7 -> o_valid stays 0 and o_ready=1 next cycle; a following input (function 2, dividend 50, divisor 100) -> o_hue=150.
